// File: rtl/fuzzy_pkg.sv
// Shared types and width helpers for the fuzzy centroid defuzzifier.
package fuzzy_pkg;

  localparam int MU_W_DEF = 8;
  localparam int X_W_DEF  = 8;
  localparam int AW_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Sized so a full frame of max grades at max address cannot overflow.
  function automatic int num_width(input int mu_w, input int x_w, input int aw);
    return mu_w + x_w + aw;
  endfunction

  function automatic int den_width(input int mu_w, input int aw);
    return mu_w + aw;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per step, MSB first; NUM_W steps after load.
// Only the low Q_W quotient bits are kept; callers guarantee the quotient fits.
module seq_divider #(
  parameter int NUM_W = 24,
  parameter int DEN_W = 16,
  parameter int Q_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [NUM_W-1:0] dividend_i,
  input  logic [DEN_W-1:0] divisor_i,
  output logic [Q_W-1:0]   quotient_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] dvd_q, dvd_d;
  logic [DEN_W-1:0] dsr_q, dsr_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEN_W:0]   shifted, trial;
  logic             fits;

  assign done_o     = (cnt_q == CNT_W'(NUM_W));
  assign quotient_o = quo_q;

  always_comb begin
    shifted = {rem_q, dvd_q[NUM_W-1]};
    trial   = shifted - {1'b0, dsr_q};
    fits    = ~trial[DEN_W];
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      dvd_d = dividend_i;
      dsr_d = divisor_i;
      rem_d = '0;
      quo_d = '0;
      cnt_d = '0;
    end else if (step_i && !done_o) begin
      // remainder stays below the divisor, so the kept result fits DEN_W bits
      rem_d = fits ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];
      quo_d = {quo_q[Q_W-2:0], fits};
      dvd_d = {dvd_q[NUM_W-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fuzzy_centroid_defuzz.sv
// Centroid defuzzifier: accumulates sum(mu*x) and sum(mu) over a frame, then divides.
// Result 25 cycles after the final sample; one sample per cycle while ready, no other stall.
module fuzzy_centroid_defuzz
  import fuzzy_pkg::*;
#(
  parameter int MU_W = MU_W_DEF,
  parameter int X_W  = X_W_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            CS,
  input  logic            cen,
  input  logic            start,
  input  logic            mu_valid,
  input  logic [MU_W-1:0] mu,
  input  logic [X_W-1:0]  x,
  input  logic            last,
  output logic            ready,
  output logic            busy,
  output logic [X_W-1:0]  crisp,
  output logic            done,
  output logic            zero_den
);

  localparam int NUM_W = num_width(MU_W, X_W, AW);
  localparam int DEN_W = den_width(MU_W, AW);
  localparam int P_W   = MU_W + X_W;

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [X_W-1:0]   crisp_q, crisp_d;
  logic             zero_den_q, zero_den_d;
  logic [P_W-1:0]   prod;
  logic [X_W-1:0]   quo;
  logic             accept, frame_end, div_done;

  assign prod   = P_W'(mu) * P_W'(x);
  assign accept = (state_q == ACC) && mu_valid;
  // the 2^AW-th sample closes the frame regardless of last
  assign frame_end = accept && (last || (cnt_q == '1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (frame_end) state_d = DIV;
      DIV:     if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    num_d      = num_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    crisp_d    = crisp_q;
    zero_den_d = zero_den_q;
    if (state_q == IDLE && start) begin
      num_d = '0;
      den_d = '0;
      cnt_d = '0;
    end
    if (accept) begin
      num_d = num_q + NUM_W'(prod);
      den_d = den_q + DEN_W'(mu);
      cnt_d = cnt_q + AW'(1);
    end
    if (state_q == DIV && div_done) begin
      zero_den_d = (den_q == '0);
      crisp_d    = (den_q == '0) ? '0 : quo;
    end
  end

  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      state_q    <= IDLE;
      num_q      <= '0;
      den_q      <= '0;
      cnt_q      <= '0;
      crisp_q    <= '0;
      zero_den_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      den_q      <= den_d;
      cnt_q      <= cnt_d;
      crisp_q    <= crisp_d;
      zero_den_q <= zero_den_d;
    end
  end

  // loaded with the totals including the closing sample
  seq_divider #(
    .NUM_W(NUM_W),
    .DEN_W(DEN_W),
    .Q_W  (X_W)
  ) u_div (
    .clk_i     (CS),
    .rst_ni    (cen),
    .load_i    (frame_end),
    .step_i    (state_q == DIV),
    .dividend_i(num_d),
    .divisor_i (den_d),
    .quotient_o(quo),
    .done_o    (div_done)
  );

  assign ready    = (state_q == ACC);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign crisp    = crisp_q;
  assign zero_den = zero_den_q;

endmodule

// File: tb/tb_fuzzy_centroid_defuzz.sv
// Random and directed frames checked against an arithmetic centroid model.
module tb_fuzzy_centroid_defuzz;

  logic       CS = 1'b0;
  logic       cen, start, mu_valid, last;
  logic [7:0] mu, x;
  logic       ready, busy, done, zero_den;
  logic [7:0] crisp;

  int total = 0;
  int bad   = 0;
  int fmu[$];
  int fx[$];

  fuzzy_centroid_defuzz dut (
    .CS(CS), .cen(cen), .start(start), .mu_valid(mu_valid), .mu(mu), .x(x),
    .last(last), .ready(ready), .busy(busy), .crisp(crisp), .done(done),
    .zero_den(zero_den)
  );

  always #5 CS = ~CS;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add(input int m, input int xv);
    fmu.push_back(m);
    fx.push_back(xv);
  endtask

  // Drives the frame held in fmu/fx; noisy adds gaps, ignored starts and stray mu_valid.
  task automatic run_frame(input string tag, input bit use_last, input bit noisy);
    longint n = 0, d = 0;
    int lat = 0, pulses = 0;
    logic [7:0] c_cap = '0;
    logic zd_cap = 1'b0, busy_after = 1'b1;
    @(negedge CS);
    start = 1'b1;
    @(negedge CS);
    start = 1'b0;
    check({tag, "/ready"}, ready, 1);
    for (int i = 0; i < fmu.size(); i++) begin
      if (noisy && $urandom_range(0, 3) == 0) begin
        mu_valid = 1'b0; start = 1'b1; mu = 8'($urandom); x = 8'($urandom);
        @(negedge CS);
      end
      mu_valid = 1'b1;
      mu = 8'(fmu[i]);
      x = 8'(fx[i]);
      last = use_last && (i == fmu.size() - 1);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      n += fmu[i] * fx[i];
      d += fmu[i];
      @(negedge CS);
    end
    mu_valid = 1'b0; last = 1'b0; start = 1'b0;
    check({tag, "/ready_off"}, ready, 0);
    for (int c = 1; c <= 60; c++) begin
      if (noisy && c < 10) begin
        start = 1'b1; mu_valid = 1'b1; last = 1'b1; mu = 8'($urandom); x = 8'($urandom);
      end else begin
        start = 1'b0; mu_valid = 1'b0; last = 1'b0;
      end
      @(negedge CS);
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = c; c_cap = crisp; zd_cap = zero_den;
        end
      end
      if (lat != 0 && c == lat + 1) busy_after = busy;
    end
    check({tag, "/latency"}, lat, 25);
    check({tag, "/pulses"}, pulses, 1);
    check({tag, "/crisp"}, c_cap, (d == 0) ? 0 : 32'(n / d));
    check({tag, "/zero_den"}, zd_cap, (d == 0) ? 1 : 0);
    check({tag, "/busy_after"}, busy_after, 0);
    fmu.delete();
    fx.delete();
  endtask

  initial begin
    int seen;
    cen = 1'b0; start = 1'b1; mu_valid = 1'b0; last = 1'b0; mu = '0; x = '0;
    repeat (3) @(negedge CS);
    check("rst/crisp", crisp, 0);
    check("rst/done", done, 0);
    check("rst/zero_den", zero_den, 0);
    check("rst/ready", ready, 0);
    check("rst/busy", busy, 0);
    start = 1'b0;
    cen = 1'b1;
    // stray samples in IDLE must not start anything
    mu_valid = 1'b1; mu = 8'd9; x = 8'd9;
    repeat (3) @(negedge CS);
    check("idle/busy", busy, 0);
    mu_valid = 1'b0;

    add(200, 37);
    run_frame("single", 1'b1, 1'b0);
    add(100, 10); add(100, 20);
    run_frame("two", 1'b1, 1'b0);
    add(1, 0); add(2, 255);
    run_frame("edge255", 1'b1, 1'b0);
    add(0, 5); add(0, 100); add(0, 255);
    run_frame("allzero", 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) add(255, i);
    run_frame("auto256", 1'b0, 1'b0);

    // reset during DIV aborts the frame
    @(negedge CS); start = 1'b1;
    @(negedge CS); start = 1'b0; mu_valid = 1'b1; mu = 8'd50; x = 8'd99; last = 1'b1;
    @(negedge CS); mu_valid = 1'b0; last = 1'b0;
    repeat (10) @(negedge CS);
    check("abort/busy_pre", busy, 1);
    cen = 1'b0;
    #1;
    check("abort/crisp", crisp, 0);
    check("abort/busy", busy, 0);
    check("abort/ready", ready, 0);
    check("abort/done", done, 0);
    @(negedge CS); cen = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CS);
      if (done || busy) seen++;
    end
    check("abort/quiet", seen, 0);

    add(30, 40); add(70, 90);
    run_frame("noisy_fixed", 1'b1, 1'b1);
    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(1, 16);
      bit zero = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++)
        add(zero ? 0 : $urandom_range(0, 255), $urandom_range(0, 255));
      run_frame($sformatf("rand%0d", f), 1'b1, f[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
